ripemd160_chain: RTL and testbench

//  - Iterative multi-block RIPEMD-160 engine. Accepts a stream of pre-padded 512-bit blocks

---
 rtl/ripemd160_pkg.sv | 68 ++++++
 rtl/ripemd160_step.sv | 41 ++++
 rtl/ripemd160_chain.sv | 163 ++++++++++++++++
 tb/tb_ripemd160_chain.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ripemd160_pkg.sv
// Shared RIPEMD-160 constants, per-step tables and helper functions for the
// multi-block chaining engine.
package ripemd160_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FOLD,
        ST_DONE
    } state_t;

    localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    // 80 four-bit entries each, step 0 in the most significant nibble.
    localparam logic [319:0] R_L_TAB = 320'h0123456789abcdef_74d1a6f3c0952eb8_3ae49f812706db5c_19ba08c4d37fe562_40597c2ae138b6fd;
    localparam logic [319:0] R_R_TAB = 320'h5e7092b4d6f81a3c_6b370d5aef8c4912_f5137e69b8c2a04d_86413bf05c2d97ae_cfa4158762de039b;
    localparam logic [319:0] S_L_TAB = 320'hbefc5879bdef6798_768db97f7cf9b7dc_bd67e9dfe8d65c75_bcefef989e56865c_9f5b68dc5cdeb856;
    localparam logic [319:0] S_R_TAB = 320'h899bdff5778beec6_9df7c89b77c76fdb_97fb866ecd5edd75_f58bee6e69c9c5f8_85c9c5e68d65fdbb;

    function automatic logic [3:0] tab4(input logic [319:0] tab, input logic [6:0] j);
        int idx;
        idx = 319 - 4 * int'(j);
        return tab[idx -: 4];
    endfunction

    function automatic logic [31:0] k_left(input logic [2:0] rnd);
        case (rnd)
            3'd0:    return 32'h00000000;
            3'd1:    return 32'h5a827999;
            3'd2:    return 32'h6ed9eba1;
            3'd3:    return 32'h8f1bbcdc;
            default: return 32'ha953fd4e;
        endcase
    endfunction

    function automatic logic [31:0] k_right(input logic [2:0] rnd);
        case (rnd)
            3'd0:    return 32'h50a28be6;
            3'd1:    return 32'h5c4dd124;
            3'd2:    return 32'h6d703ef3;
            3'd3:    return 32'h7a6d76e9;
            default: return 32'h00000000;
        endcase
    endfunction

    // Boolean function selected by round (j/16); the right line uses round 4-j/16.
    function automatic logic [31:0] rmd_f(input logic [2:0] rnd, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] z);
        case (rnd)
            3'd0:    return x ^ y ^ z;
            3'd1:    return (x & y) | (~x & z);
            3'd2:    return (x | ~y) ^ z;
            3'd3:    return (x & z) | (y & ~z);
            default: return x ^ (y | ~z);
        endcase
    endfunction

    function automatic logic [31:0] rol32(input logic [31:0] v, input logic [3:0] s);
        logic [63:0] w;
        w = {v, v} << s;
        return w[63:32];
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/ripemd160_step.sv
// One combinational RIPEMD-160 step applied to both the left and right lines.
module ripemd160_step
    import ripemd160_pkg::*;
(
    input  logic [6:0]   i_j,
    input  logic [511:0] i_block,
    input  logic [159:0] i_left,
    input  logic [159:0] i_right,
    output logic [159:0] o_left,
    output logic [159:0] o_right
);

    logic [31:0] w_x [16];
    logic [2:0]  w_rnd_l;
    logic [2:0]  w_rnd_r;
    logic [31:0] w_al, w_bl, w_cl, w_dl, w_el;
    logic [31:0] w_ar, w_br, w_cr, w_dr, w_er;
    logic [31:0] w_tl, w_tr;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_word
            assign w_x[gi] = i_block[511 - 32 * gi -: 32];
        end
    endgenerate

    assign w_rnd_l = i_j[6:4];
    assign w_rnd_r = 3'd4 - i_j[6:4];

    assign {w_al, w_bl, w_cl, w_dl, w_el} = i_left;
    assign {w_ar, w_br, w_cr, w_dr, w_er} = i_right;

    // K' follows the step's round order, while f runs the rounds backwards.
    assign w_tl = rol32(w_al + rmd_f(w_rnd_l, w_bl, w_cl, w_dl) + w_x[tab4(R_L_TAB, i_j)]
                        + k_left(w_rnd_l), tab4(S_L_TAB, i_j)) + w_el;
    assign w_tr = rol32(w_ar + rmd_f(w_rnd_r, w_br, w_cr, w_dr) + w_x[tab4(R_R_TAB, i_j)]
                        + k_right(w_rnd_l), tab4(S_R_TAB, i_j)) + w_er;

    assign o_left  = {w_el, w_tl, w_bl, rol32(w_cl, 4'd10), w_dl};
    assign o_right = {w_er, w_tr, w_br, rol32(w_cr, 4'd10), w_dr};

endmodule

// File: rtl/ripemd160_chain.sv
// Iterative multi-block RIPEMD-160 engine: runs both lines STEPS_PER_CYCLE steps
// per clock, chains H across blocks and hands the digest off with valid/ready.
module ripemd160_chain
    import ripemd160_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 4,
    parameter bit OUT_BYTE_SWAP   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [159:0] out_digest,
    output logic         busy
);

    localparam logic [6:0] STEP_INC = 7'(STEPS_PER_CYCLE);
    localparam logic [6:0] LAST_CNT = 7'(80 - STEPS_PER_CYCLE);

    state_t       r_state;
    state_t       w_state_next;
    logic         w_accept;
    logic [6:0]   r_cnt;
    logic [511:0] r_block;
    logic         r_last;
    logic [159:0] r_left, r_right;
    logic [159:0] r_h;
    logic [159:0] r_digest;
    logic [159:0] w_left_end, w_right_end;
    logic [159:0] w_h_fold;
    logic [159:0] w_digest_fmt;
    logic [31:0]  w_hb [5];
    logic [31:0]  w_l [5];
    logic [31:0]  w_r [5];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_state_next = ST_FOLD;
                end
            end
            ST_FOLD: begin
                busy         = 1'b1;
                w_state_next = r_last ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Each stage owns its wires so the chain is not one self-referencing array.
    generate
        for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
            logic [159:0] w_left_in, w_right_in, w_left_out, w_right_out;
            if (gi == 0) begin : g_head
                assign w_left_in  = r_left;
                assign w_right_in = r_right;
            end else begin : g_tail
                assign w_left_in  = g_step[gi-1].w_left_out;
                assign w_right_in = g_step[gi-1].w_right_out;
            end
            ripemd160_step u_step (
                .i_j     (r_cnt + 7'(gi)),
                .i_block (r_block),
                .i_left  (w_left_in),
                .i_right (w_right_in),
                .o_left  (w_left_out),
                .o_right (w_right_out)
            );
        end
    endgenerate

    assign w_left_end  = g_step[STEPS_PER_CYCLE-1].w_left_out;
    assign w_right_end = g_step[STEPS_PER_CYCLE-1].w_right_out;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_word
            assign w_hb[gi] = r_h[159 - 32 * gi -: 32];
            assign w_l[gi]  = r_left[159 - 32 * gi -: 32];
            assign w_r[gi]  = r_right[159 - 32 * gi -: 32];
            assign w_digest_fmt[159 - 32 * gi -: 32] = OUT_BYTE_SWAP ? bswap32(w_h_fold[159 - 32 * gi -: 32])
                                                                     : w_h_fold[159 - 32 * gi -: 32];
        end
    endgenerate

    // Word index 0..4 is A..E of each line; r_h still holds this block's base H.
    assign w_h_fold = {w_hb[1] + w_l[2] + w_r[3],
                       w_hb[2] + w_l[3] + w_r[4],
                       w_hb[3] + w_l[4] + w_r[0],
                       w_hb[4] + w_l[0] + w_r[1],
                       w_hb[0] + w_l[1] + w_r[2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_block  <= '0;
            r_last   <= 1'b0;
            r_left   <= '0;
            r_right  <= '0;
            r_h      <= IV;
            r_digest <= '0;
        end else begin
            if (w_accept) begin
                r_block <= in_block;
                r_last  <= in_last;
                r_cnt   <= '0;
                r_left  <= in_first ? IV : r_h;
                r_right <= in_first ? IV : r_h;
                if (in_first) begin
                    r_h <= IV;
                end
            end
            if (r_state == ST_RUN) begin
                r_left  <= w_left_end;
                r_right <= w_right_end;
                r_cnt   <= r_cnt + STEP_INC;
            end
            if (r_state == ST_FOLD) begin
                if (r_last) begin
                    r_digest <= w_digest_fmt;
                    r_h      <= IV;
                end else begin
                    r_h <= w_h_fold;
                end
            end
        end
    end

    assign out_digest = r_digest;

endmodule

// File: tb/tb_ripemd160_chain.sv
// Directed and randomized bench for ripemd160_chain against a byte-level
// RIPEMD-160 reference (padding, chaining and digest formatting done here).
module tb_ripemd160_chain;

    localparam int S   = 4;
    localparam int LAT = 80 / S + 1;

    localparam logic [319:0] TR_L = 320'h0123456789abcdef74d1a6f3c0952eb83ae49f812706db5c19ba08c4d37fe56240597c2ae138b6fd;
    localparam logic [319:0] TR_R = 320'h5e7092b4d6f81a3c6b370d5aef8c4912f5137e69b8c2a04d86413bf05c2d97aecfa4158762de039b;
    localparam logic [319:0] TS_L = 320'hbefc5879bdef6798768db97f7cf9b7dcbd67e9dfe8d65c75bcefef989e56865c9f5b68dc5cdeb856;
    localparam logic [319:0] TS_R = 320'h899bdff5778beec69df7c89b77c76fdb97fb866ecd5edd75f58bee6e69c9c5f885c9c5e68d65fdbb;
    localparam logic [31:0]  KL_M [5] = '{32'h00000000, 32'h5a827999, 32'h6ed9eba1, 32'h8f1bbcdc, 32'ha953fd4e};
    localparam logic [31:0]  KR_M [5] = '{32'h50a28be6, 32'h5c4dd124, 32'h6d703ef3, 32'h7a6d76e9, 32'h00000000};
    localparam logic [159:0] IV_M = 160'h67452301efcdab8998badcfe10325476c3d2e1f0;
    localparam logic [159:0] D_EMPTY = 160'h9c1185a5c5e9fc54612808977ee8f548b2258d31;
    localparam logic [159:0] D_ABC   = 160'h8eb208f7e05d987a9b044a8e98c6b087f15a0bfc;
    localparam logic [159:0] D_LONG  = 160'h12a053384a9c0c88e405a06c27dcf49ada62eb2b;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;
    logic [511:0] in_block = '0;
    logic         in_ready, out_valid, busy;
    logic [159:0] out_digest;

    ripemd160_chain #(.STEPS_PER_CYCLE(S), .OUT_BYTE_SWAP(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_block   (in_block),
        .in_first   (in_first),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digest (out_digest),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0]   msg_q [$];
    logic [511:0] blk_q [$];

    task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [31:0] fr(input int rnd, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        case (rnd)
            0:       return x ^ y ^ z;
            1:       return (x & y) | (~x & z);
            2:       return (x | ~y) ^ z;
            3:       return (x & z) | (y & ~z);
            default: return x ^ (y | ~z);
        endcase
    endfunction

    function automatic logic [31:0] bswap_m(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [159:0] mdl_compress(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] x [16];
        logic [31:0] al, bl, cl, dl, el, ar, br, cr, dr, er, t;
        int rl, rr, sl, sr;
        for (int j = 0; j < 16; j++) x[j] = blk[511 - 32 * j -: 32];
        {al, bl, cl, dl, el} = h;
        {ar, br, cr, dr, er} = h;
        for (int j = 0; j < 80; j++) begin
            rl = int'(TR_L[319 - 4 * j -: 4]);
            rr = int'(TR_R[319 - 4 * j -: 4]);
            sl = int'(TS_L[319 - 4 * j -: 4]);
            sr = int'(TS_R[319 - 4 * j -: 4]);
            t  = rol(al + fr(j / 16, bl, cl, dl) + x[rl] + KL_M[j / 16], sl) + el;
            al = el; el = dl; dl = rol(cl, 10); cl = bl; bl = t;
            t  = rol(ar + fr(4 - j / 16, br, cr, dr) + x[rr] + KR_M[j / 16], sr) + er;
            ar = er; er = dr; dr = rol(cr, 10); cr = br; br = t;
        end
        return {h[127:96] + cl + dr, h[95:64] + dl + er, h[63:32] + el + ar,
                h[31:0] + al + br, h[159:128] + bl + cr};
    endfunction

    function automatic logic [159:0] mdl_digest();
        logic [159:0] h;
        h = IV_M;
        foreach (blk_q[i]) h = mdl_compress(h, blk_q[i]);
        return {bswap_m(h[159:128]), bswap_m(h[127:96]), bswap_m(h[95:64]),
                bswap_m(h[63:32]), bswap_m(h[31:0])};
    endfunction

    // Standard MD-style padding: 0x80, zeros, 64-bit little-endian bit length.
    task automatic pad_msg();
        logic [7:0]   p [$];
        logic [63:0]  bits;
        logic [511:0] b;
        p = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(8'(bits >> (8 * i)));
        blk_q.delete();
        for (int base = 0; base < p.size(); base += 64) begin
            for (int j = 0; j < 16; j++)
                b[511 - 32 * j -: 32] = {p[base + 4*j + 3], p[base + 4*j + 2], p[base + 4*j + 1], p[base + 4*j]};
            blk_q.push_back(b);
        end
    endtask

    task automatic set_str(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
        pad_msg();
    endtask

    task automatic chk_reset(input string tag);
        check_bit({tag, "_in_ready"}, in_ready, 1'b1);
        check_bit({tag, "_out_valid"}, out_valid, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_digest"}, out_digest, 160'h0);
    endtask

    task automatic send_block(input logic [511:0] b, input logic f, input logic l);
        @(negedge clk);
        check_bit("send_in_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_block = b; in_first = f; in_last = l;
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        check_bit("accept_busy", busy, 1'b1);
        check_bit("accept_in_ready", in_ready, 1'b0);
    endtask

    task automatic wait_in_ready();
        int k = 0;
        do begin @(posedge clk); #1; k++; end while (!in_ready && k < 300);
        check_int("block_to_idle_cycles", k, LAT);
    endtask

    task automatic wait_out_valid();
        int k = 0;
        do begin @(posedge clk); #1; k++; end while (!out_valid && k < 300);
        check_int("last_to_valid_cycles", k, LAT);
        check_bit("done_in_ready", in_ready, 1'b0);
    endtask

    task automatic run_msg(input logic first0, output logic [159:0] dig);
        for (int i = 0; i < blk_q.size(); i++) begin
            send_block(blk_q[i], (i == 0) ? first0 : 1'b0, i == blk_q.size() - 1);
            if (i == blk_q.size() - 1) wait_out_valid();
            else wait_in_ready();
        end
        dig = out_digest;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check_bit("handoff_out_valid", out_valid, 1'b0);
        check_bit("handoff_in_ready", in_ready, 1'b1);
        check_val("digest_kept", out_digest, dig);
        $display("msg blocks=%0d digest=%h", blk_q.size(), dig);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] d;
        logic [159:0] exp;
        bit abandon;

        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;

        set_str("");
        run_msg(1'b1, d);
        check_val("empty", d, D_EMPTY);
        check_val("empty_model", d, mdl_digest());

        set_str("abc");
        run_msg(1'b1, d);
        check_val("abc", d, D_ABC);
        check_val("abc_model", d, mdl_digest());

        set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        run_msg(1'b1, d);
        check_val("two_block", d, D_LONG);
        check_val("two_block_model", d, mdl_digest());

        // Digest held under backpressure while a competing block is offered.
        set_str("abc");
        send_block(blk_q[0], 1'b1, 1'b1);
        wait_out_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) begin
                in_valid = 1'b1; in_block = {16{$urandom}}; in_first = 1'b1; in_last = 1'b1;
            end
            check_val("bp_digest", out_digest, D_ABC);
            check_bit("bp_in_ready", in_ready, 1'b0);
            check_bit("bp_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check_bit("bp_release_out_valid", out_valid, 1'b0);
        check_bit("bp_release_busy", busy, 1'b0);
        $display("backpressure release digest=%h", out_digest);
        run_msg(1'b1, d);
        check_val("abc_after_bp", d, D_ABC);

        // Reset in the middle of the first block of a two-block message.
        set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        send_block(blk_q[0], 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk_reset("mid_run_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset("after_reset");
        set_str("abc");
        run_msg(1'b1, d);
        check_val("abc_after_reset", d, D_ABC);

        // Random messages; some abandon an open message, some start with in_first=0.
        for (int m = 0; m < 8; m++) begin
            msg_q.delete();
            for (int i = 0; i < int'($urandom_range(0, 200)); i++) msg_q.push_back(8'($urandom));
            pad_msg();
            exp = mdl_digest();
            abandon = (m % 3 == 0);
            @(negedge clk); out_ready = 1'b1;
            @(negedge clk); out_ready = 1'b0;
            check_bit("idle_out_ready_out_valid", out_valid, 1'b0);
            check_bit("idle_out_ready_busy", busy, 1'b0);
            if (abandon) begin
                send_block({16{$urandom}}, 1'b1, 1'b0);
                wait_in_ready();
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_msg(abandon ? 1'b1 : 1'($urandom_range(0, 1)), d);
            check_val("rand_msg", d, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
